mem_client: RTL and testbench

MEM_CLIENT -- requirements
Module: mem_client

---
 rtl/mem_client.sv | 147 ++++++++++++++
 tb/tb_mem_client.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_client.sv
// mem_client: turns single local commands into a request/acknowledge memory
// transaction with a bounded wait.
//
// A command handshakes on cmd_valid & cmd_ready, then rq is held high with
// stable address/wr_ni/dataW until the memory raises ack or the wait budget
// (TIMEOUT cycles) runs out. Either way a one-cycle rsp_valid pulse reports
// completion (rsp_err marks a timeout) while rq is forced low for one cycle
// before the next command can be taken.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   cmd_valid/cmd_ready   local command handshake
//   cmd_wr_ni             1 = read, 0 = write
//   cmd_addr, cmd_wdata   command address and write data
//   rsp_valid, rsp_err    completion pulse and timeout flag
//   rsp_rdata             read data, held until the next successful read
//   rq, address, wr_ni,   memory request side, all registered
//   dataW
//   ack, dataR            memory acknowledge and read data
module mem_client #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_wr_ni,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_err,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rq,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  wr_ni,
  output logic [DATA_WIDTH-1:0] dataW,
  input  logic                  ack,
  input  logic [DATA_WIDTH-1:0] dataR
);

  // wait_cnt value seen on the edge that ends the TIMEOUT-th rq-high cycle.
  localparam logic [7:0] WaitLast = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StReq     = 2'd1,
    StRelease = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  rq_q, rq_d;
  logic [ADDR_WIDTH-1:0] address_q, address_d;
  logic                  wr_ni_q, wr_ni_d;
  logic [DATA_WIDTH-1:0] dataw_q, dataw_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [7:0]            wait_cnt_q, wait_cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      rq_q        <= 1'b0;
      address_q   <= '0;
      wr_ni_q     <= 1'b0;
      dataw_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      rq_q        <= rq_d;
      address_q   <= address_d;
      wr_ni_q     <= wr_ni_d;
      dataw_q     <= dataw_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rq_d        = rq_q;
    address_d   = address_q;
    wr_ni_d     = wr_ni_q;
    dataw_d     = dataw_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    wait_cnt_d  = wait_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          address_d  = cmd_addr;
          wr_ni_d    = cmd_wr_ni;
          dataw_d    = cmd_wdata;
          rq_d       = 1'b1;
          wait_cnt_d = '0;
          state_d    = StReq;
        end
      end
      StReq: begin
        if (ack) begin
          // ack beats a simultaneous timeout
          rq_d        = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          if (wr_ni_q) rsp_rdata_d = dataR;
          state_d     = StRelease;
        end else begin
          if (wait_cnt_q != 8'hFF) wait_cnt_d = wait_cnt_q + 8'd1;
          if (wait_cnt_q == WaitLast) begin
            rq_d        = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            state_d     = StRelease;
          end
        end
      end
      StRelease: begin
        // one guaranteed rq-low cycle so the memory can re-arm
        rq_d    = 1'b0;
        state_d = StIdle;
      end
      default: begin
        rq_d    = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  assign cmd_ready = (state_q == StIdle);
  assign rq        = rq_q;
  assign address   = address_q;
  assign wr_ni     = wr_ni_q;
  assign dataW     = dataw_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_mem_client.sv
// Bench for mem_client paired with a small memory model (ack delay 2).
module tb_mem_client;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int D  = 2;

  logic          clk, reset;
  logic          cmd_valid, cmd_ready, cmd_wr_ni;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          rq, wr_ni, ack;
  logic [AW-1:0] address;
  logic [DW-1:0] dataW, dataR;

  int vec  = 0;
  int miss = 0;

  // ack source: 0 = memory model, 1 = tied low, 2 = driven by the bench
  int   ack_mode = 0;
  logic ack_man  = 1'b0;

  logic [DW-1:0] mem [16];
  int            mem_cnt;
  logic          model_ack;

  mem_client #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .TIMEOUT   (16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_wr_ni(cmd_wr_ni),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_err  (rsp_err),
    .rsp_rdata(rsp_rdata),
    .rq       (rq),
    .address  (address),
    .wr_ni    (wr_ni),
    .dataW    (dataW),
    .ack      (ack),
    .dataR    (dataR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: counts edges with rq high, acks once D such edges have passed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset || !rq) mem_cnt <= 0;
    else if (mem_cnt < D) mem_cnt <= mem_cnt + 1;
  end
  assign model_ack = rq && (mem_cnt >= D);
  assign ack = (ack_mode == 0) ? model_ack : (ack_mode == 2) ? ack_man : 1'b0;
  assign dataR = mem[address];

  always_ff @(posedge clk) begin
    if (rq && ack && !wr_ni) mem[address] <= dataW;
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    vec++; if (rq !== 1'b0) begin miss++; $display("FAIL rst_rq got %0b want 0", rq); end
    vec++; if (rsp_valid !== 1'b0) begin miss++; $display("FAIL rst_rsp_valid got %0b want 0", rsp_valid); end
    vec++; if (rsp_err !== 1'b0) begin miss++; $display("FAIL rst_rsp_err got %0b want 0", rsp_err); end
    vec++; if (rsp_rdata !== 8'h00) begin miss++; $display("FAIL rst_rsp_rdata got %h want 00", rsp_rdata); end
    vec++; if ({address, wr_ni, dataW} !== 13'h0) begin miss++; $display("FAIL rst_mem_bus got %h want 0", {address, wr_ni, dataW}); end
    vec++; if (cmd_ready !== 1'b1) begin miss++; $display("FAIL rst_cmd_ready got %0b want 1", cmd_ready); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_write;
    cmd_valid = 1'b1; cmd_wr_ni = 1'b0; cmd_addr = 4'd3; cmd_wdata = 8'h5A;
    tick(); // T0
    cmd_valid = 1'b0;
    vec++; if ({rq, cmd_ready} !== 2'b10) begin miss++; $display("FAIL wr_t0_rq_ready got %b want 10", {rq, cmd_ready}); end
    vec++; if ({address, wr_ni, dataW} !== {4'd3, 1'b0, 8'h5A}) begin miss++; $display("FAIL wr_t0_bus got %h want %h", {address, wr_ni, dataW}, {4'd3, 1'b0, 8'h5A}); end
    tick(); // T0+1
    tick(); // T0+2
    vec++; if ({rq, rsp_valid} !== 2'b10) begin miss++; $display("FAIL wr_t2_rq_rsp got %b want 10", {rq, rsp_valid}); end
    tick(); // T0+3
    vec++; if ({rq, rsp_valid, rsp_err} !== 3'b010) begin miss++; $display("FAIL wr_t3_rq_rsp_err got %b want 010", {rq, rsp_valid, rsp_err}); end
    vec++; if (rsp_rdata !== 8'h00) begin miss++; $display("FAIL wr_t3_rdata_kept got %h want 00", rsp_rdata); end
    vec++; if (cmd_ready !== 1'b0) begin miss++; $display("FAIL wr_t3_cmd_ready got %0b want 0", cmd_ready); end
    tick(); // T0+4
    vec++; if ({rq, rsp_valid, cmd_ready} !== 3'b001) begin miss++; $display("FAIL wr_t4_rq_rsp_ready got %b want 001", {rq, rsp_valid, cmd_ready}); end
  endtask

  task automatic test_read;
    cmd_valid = 1'b1; cmd_wr_ni = 1'b1; cmd_addr = 4'd3; cmd_wdata = 8'hFF;
    tick();
    cmd_valid = 1'b0;
    vec++; if ({rq, wr_ni, address} !== {1'b1, 1'b1, 4'd3}) begin miss++; $display("FAIL rd_t0_bus got %h want %h", {rq, wr_ni, address}, {1'b1, 1'b1, 4'd3}); end
    tick();
    tick();
    tick(); // T0+3
    vec++; if ({rsp_valid, rsp_err} !== 2'b10) begin miss++; $display("FAIL rd_rsp_err got %b want 10", {rsp_valid, rsp_err}); end
    vec++; if (rsp_rdata !== 8'h5A) begin miss++; $display("FAIL rd_rdata got %h want 5a", rsp_rdata); end
    tick();
  endtask

  task automatic test_back_to_back;
    int            t_first, t_second, low_between, addr_bad, rsp_cnt, dbl;
    logic          pr, prq, prv;
    logic [AW-1:0] pa;
    logic [DW-1:0] rd1;
    t_first = -1; t_second = -1; low_between = 0; addr_bad = 0; rsp_cnt = 0; dbl = 0;
    rd1 = '0; prv = 1'b0;
    cmd_valid = 1'b1; cmd_wr_ni = 1'b1; cmd_addr = 4'd3; cmd_wdata = 8'h00;
    for (int c = 0; c < 16; c++) begin
      pr = cmd_ready; prq = rq; pa = address; prv = rsp_valid;
      tick();
      if (pr && cmd_valid) begin
        if (t_first < 0) begin
          t_first = c;
          cmd_wr_ni = 1'b0; cmd_addr = 4'd7; cmd_wdata = 8'hC3;
        end else if (t_second < 0) begin
          t_second = c;
          cmd_valid = 1'b0;
        end
      end
      if (prq && rq && address !== pa) addr_bad++;
      if (t_first >= 0 && t_second < 0 && !rq) low_between++;
      if (prv && rsp_valid) dbl++;
      if (rsp_valid) begin
        rsp_cnt++;
        if (rsp_cnt == 1) rd1 = rsp_rdata;
      end
    end
    vec++; if (t_second - t_first !== 5) begin miss++; $display("FAIL b2b_spacing got %0d want 5", t_second - t_first); end
    vec++; if (low_between !== 2) begin miss++; $display("FAIL b2b_rq_low got %0d want 2", low_between); end
    vec++; if (addr_bad !== 0) begin miss++; $display("FAIL b2b_addr_stable got %0d want 0", addr_bad); end
    vec++; if (rsp_cnt !== 2) begin miss++; $display("FAIL b2b_rsp_count got %0d want 2", rsp_cnt); end
    vec++; if (dbl !== 0) begin miss++; $display("FAIL b2b_rsp_double got %0d want 0", dbl); end
    vec++; if (rd1 !== 8'h5A) begin miss++; $display("FAIL b2b_rdata got %h want 5a", rd1); end
  endtask

  task automatic test_timeout;
    int  hi;
    logic got;
    ack_mode = 1;
    hi = 0; got = 1'b0;
    cmd_valid = 1'b1; cmd_wr_ni = 1'b1; cmd_addr = 4'd3;
    tick(); // T0
    cmd_valid = 1'b0;
    if (rq) hi++;
    for (int c = 0; c < 40 && !got; c++) begin
      tick();
      if (rsp_valid) got = 1'b1;
      else if (rq) hi++;
    end
    vec++; if (got !== 1'b1) begin miss++; $display("FAIL to_rsp_seen got %0b want 1", got); end
    vec++; if (hi !== 16) begin miss++; $display("FAIL to_rq_cycles got %0d want 16", hi); end
    vec++; if ({rq, rsp_err, cmd_ready} !== 3'b010) begin miss++; $display("FAIL to_rq_err_ready got %b want 010", {rq, rsp_err, cmd_ready}); end
    vec++; if (rsp_rdata !== 8'h5A) begin miss++; $display("FAIL to_rdata_kept got %h want 5a", rsp_rdata); end
    tick();
    vec++; if ({cmd_ready, rsp_valid} !== 2'b10) begin miss++; $display("FAIL to_after_ready_rsp got %b want 10", {cmd_ready, rsp_valid}); end
    ack_mode = 0;
  endtask

  task automatic test_ack_on_timeout;
    ack_mode = 2; ack_man = 1'b0;
    cmd_valid = 1'b1; cmd_wr_ni = 1'b1; cmd_addr = 4'd7;
    tick(); // T0
    cmd_valid = 1'b0;
    for (int c = 1; c <= 15; c++) tick();
    vec++; if ({rq, rsp_valid} !== 2'b10) begin miss++; $display("FAIL race_t15_rq_rsp got %b want 10", {rq, rsp_valid}); end
    ack_man = 1'b1;
    tick(); // T0+16
    ack_man = 1'b0;
    vec++; if ({rsp_valid, rsp_err, rq} !== 3'b100) begin miss++; $display("FAIL race_rsp_err_rq got %b want 100", {rsp_valid, rsp_err, rq}); end
    vec++; if (rsp_rdata !== 8'hC3) begin miss++; $display("FAIL race_rdata got %h want c3", rsp_rdata); end
    tick();
    ack_mode = 0;
  endtask

  task automatic test_reset_mid_req;
    int seen;
    seen = 0;
    cmd_valid = 1'b1; cmd_wr_ni = 1'b0; cmd_addr = 4'd5; cmd_wdata = 8'h11;
    tick(); // T0
    cmd_valid = 1'b0;
    tick(); // T0+1, still requesting
    vec++; if (rq !== 1'b1) begin miss++; $display("FAIL rr_pre_rq got %0b want 1", rq); end
    #2 reset = 1'b1;
    #1;
    vec++; if (rq !== 1'b0) begin miss++; $display("FAIL rr_async_rq got %0b want 0", rq); end
    vec++; if ({address, dataW} !== 12'h0) begin miss++; $display("FAIL rr_async_bus got %h want 0", {address, dataW}); end
    tick();
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (rsp_valid || rq) seen++;
    end
    vec++; if (seen !== 0) begin miss++; $display("FAIL rr_no_completion got %0d want 0", seen); end
    cmd_valid = 1'b1; cmd_wr_ni = 1'b1; cmd_addr = 4'd3;
    tick();
    cmd_valid = 1'b0;
    vec++; if (rq !== 1'b1) begin miss++; $display("FAIL rr_first_accept got %0b want 1", rq); end
    tick();
    tick();
    tick();
    vec++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 8'h5A}) begin miss++; $display("FAIL rr_next_cmd got %h want %h", {rsp_valid, rsp_err, rsp_rdata}, {2'b10, 8'h5A}); end
    tick();
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_wr_ni = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_timeout();
    test_ack_on_timeout();
    test_reset_mid_req();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
